// File: rtl/enable_burst_sequencer.sv
// enable_burst_sequencer: turns accepted enable pulses into a delayed burst of spaced triggers.
// Define ENABLE_BURST_SEQUENCER_OVERRUN_EN to build the saturating dropped-pulse counter.
module enable_burst_sequencer #(
  parameter int COUNTER_WIDTH = 32,
  parameter int BURST_WIDTH   = 8,
  parameter int OVERRUN_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable_in,
  input  logic                     sequencer_enable,
  input  logic [COUNTER_WIDTH-1:0] delay,
  input  logic [COUNTER_WIDTH-1:0] spacing,
  input  logic [BURST_WIDTH-1:0]   burst_length,
  output logic                     trigger_out,
  output logic [BURST_WIDTH-1:0]   trigger_index,
  output logic                     busy,
  output logic                     done,
  output logic [OVERRUN_WIDTH-1:0] overrun_count
);
  typedef enum logic [1:0] {IDLE, DELAY, PULSE, GAP} state_t;
  localparam logic [COUNTER_WIDTH-1:0] C1 = 1;
  localparam logic [BURST_WIDTH-1:0]   B1 = 1;
  state_t                   state;
  logic [COUNTER_WIDTH-1:0] cnt, d_l, s_l;
  logic [BURST_WIDTH-1:0]   idx, n_l;
  // DELAY and GAP share one counter; it starts at 1 so it stops exactly on the latched length
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      d_l           <= '0;
      s_l           <= '0;
      n_l           <= '0;
      trigger_out   <= 1'b0;
      trigger_index <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      trigger_out   <= 1'b0;
      trigger_index <= '0;
      done          <= 1'b0;
      if (!sequencer_enable) begin
        state <= IDLE;
        busy  <= 1'b0;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: if (enable_in && burst_length != '0) begin
            d_l         <= delay;
            s_l         <= spacing;
            n_l         <= burst_length;
            idx         <= '0;
            cnt         <= C1;
            busy        <= 1'b1;
            state       <= (delay == '0) ? PULSE : DELAY;
            trigger_out <= (delay == '0);
          end
          DELAY, GAP: if (cnt == ((state == DELAY) ? d_l : s_l)) begin
            state         <= PULSE;
            trigger_out   <= 1'b1;
            trigger_index <= idx;
          end else begin
            cnt <= cnt + C1;
          end
          PULSE: if (idx == n_l - B1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            idx   <= '0;
          end else begin
            idx           <= idx + B1;
            cnt           <= C1;
            state         <= (s_l == '0) ? PULSE : GAP;
            trigger_out   <= (s_l == '0);
            trigger_index <= (s_l == '0) ? idx + B1 : '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef ENABLE_BURST_SEQUENCER_OVERRUN_EN
  logic en_q;
  logic overrun;
  assign overrun = enable_in && sequencer_enable && state != IDLE;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q          <= 1'b0;
      overrun_count <= '0;
    end else begin
      en_q <= sequencer_enable;
      if (sequencer_enable && !en_q)
        overrun_count <= OVERRUN_WIDTH'(overrun);
      else if (overrun && overrun_count != '1)
        overrun_count <= overrun_count + OVERRUN_WIDTH'(1);
    end
  end
`else
  assign overrun_count = '0;
`endif
endmodule
